// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

    // Default operand/result width.
    localparam int DIV_LENGTH = 32;

    // Controller states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract d,
// keep the difference and set the new quotient bit when it is non-negative.
module div_step #(
    parameter int LENGTH = 32
) (
    input  logic [LENGTH:0]   r,
    input  logic [LENGTH-1:0] q,
    input  logic [LENGTH-1:0] d,
    output logic [LENGTH:0]   r_next,
    output logic [LENGTH-1:0] q_next
);

    logic [LENGTH:0] r_shifted;
    logic [LENGTH:0] trial;

    // Shift, trial-subtract and select the restored or reduced remainder.
    always_comb begin
        r_shifted = {r[LENGTH-1:0], q[LENGTH-1]};
        trial     = r_shifted - {1'b0, d};
        r_next    = r_shifted;
        q_next    = {q[LENGTH-2:0], 1'b0};
        if (!trial[LENGTH]) begin
            r_next = trial;
            q_next = {q[LENGTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One quotient bit per cycle; divide-by-zero bypasses the iteration.
import seq_divider_pkg::*;

module seq_divider #(
    parameter int LENGTH = DIV_LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LENGTH-1:0] dividend,
    input  logic [LENGTH-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [LENGTH-1:0] quotient,
    output logic [LENGTH-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CW = $clog2(LENGTH);

    div_state_e        state;
    div_state_e        state_next;
    logic [LENGTH:0]   r_reg;
    logic [LENGTH-1:0] q_reg;
    logic [LENGTH-1:0] d_reg;
    logic [CW-1:0]     cnt;
    logic [LENGTH:0]   r_next;
    logic [LENGTH-1:0] q_next;
    logic              accept;
    logic              zero_div;
    logic              last_iter;

    div_step #(.LENGTH(LENGTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_next),
        .q_next (q_next)
    );

    assign zero_div  = (divisor == '0);
    assign last_iter = (cnt == CW'(LENGTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = zero_div ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                done       = 1'b1;
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    // Operand capture and per-cycle iteration of the working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
            q_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            r_reg <= '0;
            q_reg <= dividend;
            d_reg <= divisor;
            cnt   <= '0;
        end else if (state == DIV_CALC) begin
            r_reg <= r_next;
            q_reg <= q_next;
            cnt   <= cnt + 1'b1;
        end
    end

    // Result registers: loaded on the edge entering DONE so they are valid
    // together with the done pulse, and held until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if ((state == DIV_CALC) && last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next[LENGTH-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (LENGTH=32) against plain arithmetic.
module tb_seq_divider;

    localparam int L = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [L-1:0]  dividend;
    logic [L-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [L-1:0]  quotient;
    logic [L-1:0]  remainder;
    logic          div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    seq_divider #(.LENGTH(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and observe it. lat counts falling edges after the
    // accepting edge until done is seen (0 = never seen within the budget).
    task automatic run_op(input logic [L-1:0] a, input logic [L-1:0] b,
                          input int inject_at,
                          output logic [L-1:0] q, output logic [L-1:0] r,
                          output logic z, output int lat, output int busy_n,
                          output logic width_ok, output logic stable);
        logic [L-1:0] q0, r0;
        logic z0;
        int k;
        @(negedge clk);
        q0 = quotient; r0 = remainder; z0 = div_by_zero;
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom;
        lat = 0; busy_n = 0; stable = 1'b1; width_ok = 1'b0;
        q = '0; r = '0; z = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = k;
                break;
            end
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) stable = 1'b0;
            if (inject_at > 0 && k == inject_at) begin
                start = 1'b1; dividend = 9; divisor = 3;
            end else if (inject_at > 0 && k == inject_at + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        q = quotient; r = remainder; z = div_by_zero;
        @(negedge clk);
        width_ok = !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        n_cmp++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    // Directed operand pairs with exact expected quotient/remainder.
    task automatic test_directed();
        logic [L-1:0] ta [4];
        logic [L-1:0] tb [4];
        logic [L-1:0] eq [4];
        logic [L-1:0] er [4];
        logic [L-1:0] q, r;
        logic z, w, s;
        int lat, bn;
        ta = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tb = '{32'd7,   32'd9, 32'd1,         32'hFFFF_FFFF};
        eq = '{32'd14,  32'd0, 32'hFFFF_FFFF, 32'd1};
        er = '{32'd2,   32'd5, 32'd0,         32'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 0, q, r, z, lat, bn, w, s);
            n_cmp++;
            if (q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                n_bad++;
                $display("FAIL directed_%0d: q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                         i, q, r, z, eq[i], er[i]);
            end
            n_cmp++;
            if (lat !== L + 1 || bn !== L) begin
                n_bad++;
                $display("FAIL directed_latency_%0d: done at %0d busy %0d, want %0d and %0d",
                         i, lat, bn, L + 1, L);
            end
            n_cmp++;
            if (w !== 1'b1 || s !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_pulse_hold_%0d: single=%b stable=%b, want 1 1", i, w, s);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [L-1:0] q, r;
        logic z, w, s;
        int lat, bn;
        run_op(32'd1234, 32'd0, 0, q, r, z, lat, bn, w, s);
        n_cmp++;
        if (q !== 32'hFFFF_FFFF || r !== 32'd1234 || z !== 1'b1) begin
            n_bad++;
            $display("FAIL div_zero_result: q=%h r=%0d dbz=%b, want ffffffff 1234 1", q, r, z);
        end
        n_cmp++;
        if (lat !== 1 || bn !== 0 || w !== 1'b1) begin
            n_bad++;
            $display("FAIL div_zero_timing: done at %0d busy %0d single=%b, want 1 0 1", lat, bn, w);
        end
        n_cmp++;
        if (div_by_zero !== 1'b1 || remainder !== 32'd1234) begin
            n_bad++;
            $display("FAIL div_zero_hold: dbz=%b r=%0d, want 1 1234", div_by_zero, remainder);
        end
    endtask

    task automatic test_ignore_start();
        logic [L-1:0] q, r;
        logic z, w, s;
        int lat, bn;
        run_op(32'd1000, 32'd10, 5, q, r, z, lat, bn, w, s);
        n_cmp++;
        if (q !== 32'd100 || r !== 32'd0 || z !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start_result: q=%0d r=%0d dbz=%b, want 100 0 0", q, r, z);
        end
        n_cmp++;
        if (lat !== L + 1 || s !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_start_timing: done at %0d stable=%b, want %0d 1", lat, s, L + 1);
        end
        // The ignored request must not have launched anything.
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd100) begin
            n_bad++;
            $display("FAIL ignore_start_no_queue: busy=%b done=%b q=%0d, want 0 0 100",
                     busy, done, quotient);
        end
    endtask

    task automatic test_async_reset();
        logic [L-1:0] q, r;
        logic z, w, s;
        int seen;
        int lat, bn;
        @(negedge clk);
        dividend = 32'd77; divisor = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            n_bad++;
            $display("FAIL async_reset_clear: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (L + 4) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL async_reset_discard: %0d busy/done cycles, want 0", seen);
        end
        run_op(32'd77, 32'd5, 0, q, r, z, lat, bn, w, s);
        n_cmp++;
        if (q !== 32'd15 || r !== 32'd2 || lat !== L + 1) begin
            n_bad++;
            $display("FAIL after_reset_op: q=%0d r=%0d lat=%0d, want 15 2 %0d", q, r, lat, L + 1);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, k;
        logic ok;
        first = 0; second = 0; ok = 1'b1;
        @(negedge clk);
        dividend = 32'd500; divisor = 32'd7; start = 1'b1;
        for (k = 1; k <= 3 * (L + 2); k++) begin
            @(negedge clk);
            if (done) begin
                if (quotient !== 32'd71 || remainder !== 32'd3) ok = 1'b0;
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
        end
        start = 1'b0;
        repeat (L + 4) @(negedge clk);
        n_cmp++;
        if (first == 0 || second == 0 || second - first != L + 2) begin
            n_bad++;
            $display("FAIL back_to_back_period: done at %0d and %0d, want spacing %0d",
                     first, second, L + 2);
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL back_to_back_result: results wrong, want q=71 r=3");
        end
    endtask

    task automatic test_random();
        logic [L-1:0] a, b, q, r;
        logic [2*L-1:0] recon;
        logic z, w, s;
        int lat, bn, sel;
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            case (sel)
                0: b = '0;
                1: b = 32'd1;
                2: b = $urandom_range(2, 15);
                3: begin a = '1; b = $urandom; end
                4: b = a;
                5: b = a + 32'd1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(a, b, 0, q, r, z, lat, bn, w, s);
            if (b == '0) begin
                n_cmp++;
                if (q !== '1 || r !== a || z !== 1'b1 || lat !== 1 || bn !== 0 || w !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rand_zero_%0d: a=%h q=%h r=%h dbz=%b lat=%0d busy=%0d single=%b",
                             i, a, q, r, z, lat, bn, w);
                end
            end else begin
                recon = {{L{1'b0}}, q} * {{L{1'b0}}, b} + {{L{1'b0}}, r};
                n_cmp++;
                if (q !== a / b || r !== a % b || z !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_value_%0d: %h/%h q=%h r=%h dbz=%b, want q=%h r=%h",
                             i, a, b, q, r, z, a / b, a % b);
                end
                n_cmp++;
                if (recon !== {{L{1'b0}}, a} || !(r < b)) begin
                    n_bad++;
                    $display("FAIL rand_invariant_%0d: q*d+r=%h r=%h, want %h and r<%h",
                             i, recon, r, a, b);
                end
                n_cmp++;
                if (lat !== L + 1 || bn !== L || w !== 1'b1 || s !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rand_timing_%0d: lat=%0d busy=%0d single=%b stable=%b, want %0d %0d 1 1",
                             i, lat, bn, w, s, L + 1, L);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
